ternary_seq_ctrl: RTL and testbench
===================================

TERNARY_SEQ_CTRL -- requirements
Module: ternary_seq_ctrl

Interface
REQ-001 SHALL have parameter InLen, default 16, input vector length in elements.
REQ-002 SHALL have parameter OutLen, default 8, output vector length and number of row steps.
REQ-003 SHALL have parameter BitWidth, default 8, element width in bits.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 SHALL have ports wt_valid/wt_ready/wt_data  in/out/in  1/1/8  weight byte stream.
REQ-007 SHALL have ports in_valid/in_ready/in_data  in/out/in  1/1/2*BitWidth  input element pairs; upper byte is the even element.
REQ-008 SHALL have ports out_valid/out_ready/out_data  out/in/out  1/1/BitWidth  result byte stream.
REQ-009 SHALL have ports mult_row/mult_en/mult_vecin/mult_w  out  3/1/2*BitWidth/32  drive to the ternary multiplier.
REQ-010 SHALL have port mult_vecout  input  BitWidth  multiplier result byte for the current mult_row.
REQ-011 SHALL have outputs weights_ok, code_err and done, each 1 bit.

Function
REQ-012 SHALL implement the FSM states IDLE, LOAD, FEED, FLUSH and DRAIN.
REQ-013 SHALL hold a 256-bit weight store; the byte accepted at index k (0..31) writes store[8k+:8].
REQ-014 SHALL decode weight codes as 2'b01=+1, 2'b11=-1 and 2'b00=0; code 2'b10 behaves as 0 and sets sticky code_err.
REQ-015 In IDLE, SHALL drive wt_ready=1 and in_ready=weights_ok; when wt_valid and in_valid are both asserted in IDLE, weight loading SHALL win.
REQ-016 A wt_valid&&wt_ready transfer in IDLE SHALL write byte 0, clear weights_ok and code_err, and enter LOAD.
REQ-017 In LOAD, SHALL hold wt_ready=1 and in_ready=0; after byte 31 is accepted it SHALL return to IDLE with weights_ok=1 on the next cycle.
REQ-018 An in_valid&&in_ready transfer in IDLE SHALL accept pair 0 and enter FEED; pair index p runs 0..OutLen-1.
REQ-019 In FEED, SHALL hold in_ready=1 and wt_ready=0.
REQ-020 Each accepted pair p SHALL, on the next cycle (1-cycle latency, registered), drive mult_row=p, mult_vecin=in_data and mult_w=store[32p+:32], with mult_en=0.
REQ-021 On a FEED stall (in_valid=0), SHALL hold mult_row and mult_w and drive mult_vecin=0, so the accumulation adds zero.
REQ-022 After pair 7 is accepted, SHALL enter FLUSH for exactly one cycle with mult_row=0, mult_en=1 and mult_vecin=0.
REQ-023 In DRAIN, SHALL sweep out_idx 0..7 with mult_row=out_idx, mult_en=0, mult_vecin=0, out_valid=1 and out_data=mult_vecout (combinational pass-through).
REQ-024 In DRAIN, SHALL hold out_idx and out_data stable while out_valid&&!out_ready.
REQ-025 After byte 7 is accepted, SHALL pulse done for one cycle and return to IDLE; weights SHALL persist across vectors.
REQ-026 Outside DRAIN, out_valid SHALL be 0; outside FLUSH, mult_en SHALL be 0.
REQ-027 All counters SHALL be 3-bit (pairs/rows) or 5-bit (bytes) and wrap to 0 only on the state exit listed above.

Reset
REQ-028 While rst_n=0, SHALL be in IDLE with the weight store, counters, mult_row, mult_vecin and mult_w = 0; mult_en, out_valid, weights_ok, code_err and done = 0; and wt_ready = 1.
REQ-029 Reset asserted mid-LOAD, mid-FEED or mid-DRAIN SHALL abandon the operation; no partial result bytes SHALL be emitted after release.

Verification
REQ-030 Scenario: load 32 bytes of 0x55 (all +1), then pairs {1,1} for p=0..7 -> mult_w=0x55555555 every row, one FLUSH cycle with mult_en=1, 8 out bytes emitted, then done pulse.
REQ-031 Scenario: load bytes 0xFF (all -1) with no wt_valid gaps -> weights_ok rises exactly 1 cycle after byte 31 is accepted, and code_err=0.
REQ-032 Scenario: byte 5 = 0xAA -> code_err=1 after load; the next load start clears it.
REQ-033 Scenario: drop in_valid for 3 cycles after pair 3 -> mult_row holds 3 and mult_vecin=0 during the gap; the pair 4 drive appears 1 cycle after its acceptance.
REQ-034 Scenario: out_ready low for 2 cycles at out_idx 2 -> mult_row=2 and out_data stable; exactly 8 out bytes, in order 0..7.
REQ-035 Scenario: assert rst_n=0 at pair 5, release, reload weights and feed a full vector -> out_valid=0 until the new DRAIN, and weights_ok=0 until the new load completes.

Source files
------------

// File: rtl/ternary_seq_ctrl.sv
// Sequencing controller for a ternary matrix-vector multiplier.
// Loads a 256-bit ternary weight store from a byte stream, feeds input
// element pairs row by row to the multiplier, issues one accumulate-flush
// cycle, then drains the per-row result bytes through a valid/ready port.
module ternary_seq_ctrl #(
   parameter int InLen    = 16,
   parameter int OutLen   = 8,
   parameter int BitWidth = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wt_valid,
   output logic                    wt_ready,
   input  logic [7:0]              wt_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [2*BitWidth-1:0]   in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [BitWidth-1:0]     out_data,
   output logic [2:0]              mult_row,
   output logic                    mult_en,
   output logic [2*BitWidth-1:0]   mult_vecin,
   output logic [31:0]             mult_w,
   input  logic [BitWidth-1:0]     mult_vecout,
   output logic                    weights_ok,
   output logic                    code_err,
   output logic                    done
);

   typedef enum logic [2:0] {IDLE, LOAD, FEED, FLUSH, DRAIN} state_t;

   localparam logic [2:0] LastRow = 3'(OutLen - 1);
   localparam int         RowBits = 2 * InLen;

   state_t         state;
   logic [255:0]   store;
   logic [4:0]     byte_idx;
   logic [2:0]     pair_idx;
   logic [2:0]     out_idx;
   logic           last_pend;
   logic           pair_take;

   // Code 2'b10 is illegal; it is stored as 2'b00 so the multiplier sees a zero weight.
   function automatic logic [7:0] clean_codes(input logic [7:0] b);
      logic [7:0] r;
      r = b;
      for (int i = 0; i < 4; i++) begin
         if (b[2*i +: 2] == 2'b10) r[2*i +: 2] = 2'b00;
      end
      return r;
   endfunction

   function automatic logic has_bad_code(input logic [7:0] b);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (b[2*i +: 2] == 2'b10) bad = 1'b1;
      end
      return bad;
   endfunction

   // Handshake readiness and result pass-through decoded from the registered state.
   // last_pend marks the cycle that shows the final pair's drive, so no further pair is taken.
   always_comb begin
      wt_ready  = (state == IDLE) || (state == LOAD);
      in_ready  = ((state == IDLE) && weights_ok) || ((state == FEED) && !last_pend);
      out_valid = (state == DRAIN);
      out_data  = mult_vecout;
      pair_take = in_valid && in_ready && !((state == IDLE) && wt_valid);
   end

   // Controller FSM with registered multiplier drive and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         store      <= '0;
         byte_idx   <= '0;
         pair_idx   <= '0;
         out_idx    <= '0;
         last_pend  <= 1'b0;
         mult_row   <= '0;
         mult_en    <= 1'b0;
         mult_vecin <= '0;
         mult_w     <= '0;
         weights_ok <= 1'b0;
         code_err   <= 1'b0;
         done       <= 1'b0;
      end else begin
         done    <= 1'b0;
         mult_en <= 1'b0;
         case (state)
            IDLE: begin
               if (wt_valid) begin
                  store[7:0] <= clean_codes(wt_data);
                  byte_idx   <= 5'd1;
                  weights_ok <= 1'b0;
                  code_err   <= has_bad_code(wt_data);
                  state      <= LOAD;
               end else if (pair_take) begin
                  state <= FEED;
               end
            end
            LOAD: begin
               if (wt_valid) begin
                  store[{byte_idx, 3'b000} +: 8] <= clean_codes(wt_data);
                  code_err <= code_err | has_bad_code(wt_data);
                  if (byte_idx == 5'd31) begin
                     byte_idx   <= 5'd0;
                     weights_ok <= 1'b1;
                     state      <= IDLE;
                  end else begin
                     byte_idx <= byte_idx + 5'd1;
                  end
               end
            end
            FEED: begin
               if (last_pend) begin
                  last_pend  <= 1'b0;
                  mult_row   <= 3'd0;
                  mult_en    <= 1'b1;
                  mult_vecin <= '0;
                  state      <= FLUSH;
               end else if (!in_valid) begin
                  // Stall: keep row and weights, feed zeros so the accumulator is unchanged.
                  mult_vecin <= '0;
               end
            end
            FLUSH: begin
               mult_row <= 3'd0;
               out_idx  <= 3'd0;
               state    <= DRAIN;
            end
            DRAIN: begin
               if (out_ready) begin
                  if (out_idx == LastRow) begin
                     out_idx  <= 3'd0;
                     mult_row <= 3'd0;
                     done     <= 1'b1;
                     state    <= IDLE;
                  end else begin
                     out_idx  <= out_idx + 3'd1;
                     mult_row <= out_idx + 3'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase

         if (pair_take) begin
            mult_row   <= pair_idx;
            mult_vecin <= in_data;
            mult_w     <= store[int'(pair_idx) * RowBits +: 32];
            if (pair_idx == LastRow) begin
               pair_idx  <= 3'd0;
               last_pend <= 1'b1;
            end else begin
               pair_idx <= pair_idx + 3'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ternary_seq_ctrl.sv
// Directed self-checking bench for ternary_seq_ctrl. The multiplier is
// modelled as returning 0x30 + mult_row, so drained bytes reveal row order.
module tb_ternary_seq_ctrl;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wt_valid = 1'b0;
   logic          wt_ready;
   logic [7:0]    wt_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [15:0]   in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [7:0]    out_data;
   logic [2:0]    mult_row;
   logic          mult_en;
   logic [15:0]   mult_vecin;
   logic [31:0]   mult_w;
   logic [7:0]    mult_vecout;
   logic          weights_ok;
   logic          code_err;
   logic          done;

   int n_chk = 0;
   int n_fail = 0;
   int hs_cnt = 0;

   logic [255:0] img_plus, img_minus, img_err, img_mix;

   ternary_seq_ctrl #(.InLen(16), .OutLen(8), .BitWidth(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_data(wt_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .mult_row(mult_row), .mult_en(mult_en), .mult_vecin(mult_vecin), .mult_w(mult_w),
      .mult_vecout(mult_vecout),
      .weights_ok(weights_ok), .code_err(code_err), .done(done)
   );

   always #5 clk = ~clk;

   assign mult_vecout = 8'h30 + {5'd0, mult_row};

   // Count every accepted result byte.
   always @(posedge clk) begin
      if (out_valid && out_ready) hs_cnt <= hs_cnt + 1;
   end

   // Called at a negedge; drives bytes first..31 back to back, returns at a negedge.
   task automatic load_weights(input logic [255:0] img, input int first);
      for (int k = first; k < 32; k++) begin
         if (k == 31) begin
            n_chk++;
            if (weights_ok !== 1'b0) begin
               n_fail++; $display("FAIL load_ok_low: weights_ok=%b required 0", weights_ok);
            end
            n_chk++;
            if (wt_ready !== 1'b1 || in_ready !== 1'b0) begin
               n_fail++; $display("FAIL load_ready: wt_ready=%b in_ready=%b required 1/0", wt_ready, in_ready);
            end
         end
         wt_valid = 1'b1;
         wt_data  = img[8*k +: 8];
         @(negedge clk);
      end
      wt_valid = 1'b0;
      wt_data  = '0;
      n_chk++;
      if (weights_ok !== 1'b1) begin
         n_fail++; $display("FAIL load_ok_high: weights_ok=%b required 1", weights_ok);
      end
   endtask

   // Called at a negedge in IDLE; feeds 8 pairs, optional 3-cycle gap after pair gap_after,
   // returns at the negedge of the FLUSH cycle.
   task automatic feed_vector(input logic [15:0] base, input logic [15:0] step,
                              input int gap_after, input logic [255:0] img);
      logic [15:0] d;
      n_chk++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL feed_ready: in_ready=%b required 1", in_ready);
      end
      in_valid = 1'b1;
      in_data  = base;
      for (int p = 0; p < 8; p++) begin
         d = base + 16'(p) * step;
         @(negedge clk);
         n_chk++;
         if (mult_row !== 3'(p) || mult_vecin !== d || mult_w !== img[32*p +: 32] || mult_en !== 1'b0) begin
            n_fail++;
            $display("FAIL feed_drive p=%0d: row=%0d vecin=%h w=%h en=%b required row=%0d vecin=%h w=%h en=0",
                     p, mult_row, mult_vecin, mult_w, mult_en, p, d, img[32*p +: 32]);
         end
         if (p == gap_after) begin
            in_valid = 1'b0;
            in_data  = 16'hDEAD;
            repeat (3) begin
               @(negedge clk);
               n_chk++;
               if (mult_row !== 3'(p) || mult_vecin !== 16'h0 || mult_w !== img[32*p +: 32]) begin
                  n_fail++;
                  $display("FAIL feed_gap: row=%0d vecin=%h w=%h required row=%0d vecin=0000 w=%h",
                           mult_row, mult_vecin, mult_w, p, img[32*p +: 32]);
               end
            end
         end
         if (p < 7) begin
            in_valid = 1'b1;
            in_data  = base + 16'(p + 1) * step;
         end else begin
            in_valid = 1'b0;
            in_data  = '0;
         end
      end
      @(negedge clk);
      n_chk++;
      if (mult_en !== 1'b1 || mult_row !== 3'd0 || mult_vecin !== 16'h0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush: en=%b row=%0d vecin=%h out_valid=%b required 1/0/0000/0",
                  mult_en, mult_row, mult_vecin, out_valid);
      end
   endtask

   // Called at the FLUSH negedge; drains 8 bytes with an optional stall, returns one cycle after done.
   task automatic drain_vector(input int stall_idx, input int stall_len);
      int base;
      base = hs_cnt;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         n_chk++;
         if (out_valid !== 1'b1 || mult_row !== 3'(k) || out_data !== 8'h30 + 8'(k) || mult_en !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_byte k=%0d: valid=%b row=%0d data=%h en=%b required 1/%0d/%h/0",
                     k, out_valid, mult_row, out_data, mult_en, k, 8'h30 + 8'(k));
         end
         if (k == stall_idx) begin
            out_ready = 1'b0;
            repeat (stall_len) begin
               @(negedge clk);
               n_chk++;
               if (out_valid !== 1'b1 || mult_row !== 3'(k) || out_data !== 8'h30 + 8'(k)) begin
                  n_fail++;
                  $display("FAIL drain_stall k=%0d: valid=%b row=%0d data=%h", k, out_valid, mult_row, out_data);
               end
            end
         end
         out_ready = 1'b1;
      end
      @(negedge clk);
      out_ready = 1'b0;
      n_chk++;
      if (done !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL done_pulse: done=%b out_valid=%b required 1/0", done, out_valid);
      end
      n_chk++;
      if (hs_cnt - base !== 8) begin
         n_fail++; $display("FAIL out_count: bytes=%0d required 8", hs_cnt - base);
      end
      @(negedge clk);
      n_chk++;
      if (done !== 1'b0) begin
         n_fail++; $display("FAIL done_clear: done=%b required 0", done);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_chk++;
      if (wt_ready !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 || mult_en !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_hs: wt_ready=%b in_ready=%b out_valid=%b en=%b required 1/0/0/0",
                  wt_ready, in_ready, out_valid, mult_en);
      end
      n_chk++;
      if (mult_row !== 3'd0 || mult_vecin !== 16'h0 || mult_w !== 32'h0) begin
         n_fail++; $display("FAIL reset_mult: row=%0d vecin=%h w=%h required 0", mult_row, mult_vecin, mult_w);
      end
      n_chk++;
      if (weights_ok !== 1'b0 || code_err !== 1'b0 || done !== 1'b0) begin
         n_fail++; $display("FAIL reset_flags: ok=%b err=%b done=%b required 0", weights_ok, code_err, done);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_plus_vector();
      load_weights(img_plus, 0);
      n_chk++;
      if (code_err !== 1'b0) begin
         n_fail++; $display("FAIL plus_code_err: code_err=%b required 0", code_err);
      end
      feed_vector(16'h0101, 16'h0000, -1, img_plus);
      drain_vector(-1, 0);
   endtask

   task automatic test_back_to_back();
      n_chk++;
      if (weights_ok !== 1'b1) begin
         n_fail++; $display("FAIL b2b_weights_kept: weights_ok=%b required 1", weights_ok);
      end
      feed_vector(16'h0203, 16'h0102, -1, img_plus);
      drain_vector(-1, 0);
   endtask

   task automatic test_minus_load();
      load_weights(img_minus, 0);
      n_chk++;
      if (code_err !== 1'b0) begin
         n_fail++; $display("FAIL minus_code_err: code_err=%b required 0", code_err);
      end
   endtask

   task automatic test_code_err();
      load_weights(img_err, 0);
      n_chk++;
      if (code_err !== 1'b1) begin
         n_fail++; $display("FAIL code_err_set: code_err=%b required 1", code_err);
      end
      // Weight byte and input pair offered together: loading must win.
      wt_valid = 1'b1;
      wt_data  = img_mix[7:0];
      in_valid = 1'b1;
      in_data  = 16'h7777;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = '0;
      n_chk++;
      if (code_err !== 1'b0 || weights_ok !== 1'b0) begin
         n_fail++; $display("FAIL code_err_clear: err=%b ok=%b required 0/0", code_err, weights_ok);
      end
      n_chk++;
      if (in_ready !== 1'b0 || mult_vecin !== 16'h0) begin
         n_fail++; $display("FAIL load_priority: in_ready=%b vecin=%h required 0/0000", in_ready, mult_vecin);
      end
      load_weights(img_mix, 1);
   endtask

   task automatic test_gap_and_stall();
      feed_vector(16'h1020, 16'h0111, 3, img_mix);
      drain_vector(2, 2);
   endtask

   task automatic test_reset_mid_feed();
      int base;
      base = hs_cnt;
      in_valid = 1'b1;
      in_data  = 16'h4000;
      for (int p = 1; p <= 5; p++) begin
         @(negedge clk);
         in_data = 16'h4000 + 16'(p);
      end
      n_chk++;
      if (mult_row !== 3'd4) begin
         n_fail++; $display("FAIL midfeed_row: row=%0d required 4", mult_row);
      end
      #2 rst_n = 1'b0;
      #1;
      n_chk++;
      if (weights_ok !== 1'b0 || mult_row !== 3'd0 || mult_w !== 32'h0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: ok=%b row=%0d w=%h out_valid=%b in_ready=%b required all 0",
                  weights_ok, mult_row, mult_w, out_valid, in_ready);
      end
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'h5555;
      repeat (6) begin
         @(negedge clk);
         n_chk++;
         if (out_valid !== 1'b0 || weights_ok !== 1'b0 || in_ready !== 1'b0 || mult_row !== 3'd0) begin
            n_fail++;
            $display("FAIL post_reset_idle: out_valid=%b ok=%b in_ready=%b row=%0d required 0",
                     out_valid, weights_ok, in_ready, mult_row);
         end
      end
      in_valid = 1'b0;
      in_data  = '0;
      n_chk++;
      if (hs_cnt !== base) begin
         n_fail++; $display("FAIL no_partial_out: bytes=%0d required 0", hs_cnt - base);
      end
      load_weights(img_mix, 0);
      feed_vector(16'h0A0B, 16'h0101, -1, img_mix);
      drain_vector(-1, 0);
   endtask

   // Bound the run in case the design stops responding.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Test sequence.
   initial begin
      logic [4:0] kk;
      for (int k = 0; k < 32; k++) begin
         kk = 5'(k);
         img_plus[8*k +: 8]  = 8'h55;
         img_minus[8*k +: 8] = 8'hFF;
         img_err[8*k +: 8]   = (k == 5) ? 8'hAA : 8'h00;
         img_mix[8*k +: 8]   = {kk[3], 1'b1, kk[2], 1'b1, kk[1], 1'b1, kk[0], 1'b1};
      end
      test_reset();
      test_plus_vector();
      test_back_to_back();
      test_minus_load();
      test_code_err();
      test_gap_and_stall();
      test_reset_mid_feed();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
